gen_hs_pipe: RTL and testbench

- Parametrised successor to the team's enable-DFF primitive: a DEPTH-stage elastic pipeline register with valid/ready handshake, per-stage valid bits, bubble collapsing, synchronous flush and an occupancy output.
- Used between core pipeline stages and on bus paths where the downstream side can stall. It replaces hand-chained enable flops plus separate valid tracking.

---
 rtl/gen_hs_pipe.sv | 97 +++++++++
 tb/tb_gen_hs_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_hs_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline register with bubble collapsing,
// synchronous flush and an occupancy count derived from the stage valid bits.
module gen_hs_pipe #(
    parameter int unsigned    DW      = 32,
    parameter int unsigned    DEPTH   = 2,
    parameter logic [DW-1:0]  DEFAULT = '0,
    localparam int unsigned   CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [CW-1:0] occ_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] up_valid;
    logic [DW-1:0]    up_data [DEPTH];
    logic [CW-1:0]    occ;

    // A stage can load when it is empty or its contents move on this cycle;
    // this ripples from the output back to the input in the same cycle.
    always_comb begin
        rdy[DEPTH] = out_ready_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~valid_q[k] | rdy[k+1];
        end
    end

    always_comb begin
        up_valid[0] = in_valid_i;
        up_data[0]  = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid[k] = valid_q[k-1];
            up_data[k]  = data_q[k-1];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/for structure can leave a latch behind.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_d[k] = up_valid[k];
                    // Data only toggles when a real beat arrives.
                    if (up_valid[k]) begin
                        data_d[k] = up_data[k];
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every stage
    // samples its neighbour's pre-edge value and beats shift by exactly one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            // NOTE: the data stages are reset as well, because the reset value
            // is visible on out_data_o; this is not a don't-care memory.
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= DEFAULT;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Occupancy depends only on registered valids, never on inputs.
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + CW'(valid_q[k]);
        end
    end

    assign in_ready_o  = rdy[0] & ~flush_i;
    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
    assign occ_o       = occ;

endmodule

// File: tb/tb_gen_hs_pipe.sv
// Scoreboard bench for gen_hs_pipe: three instances (DEPTH 3, 4, 2) checked
// every cycle against a beat-age model plus directed spot checks.
module tb_gen_hs_pipe;

    localparam int          NI       = 3;
    localparam int          DEP [NI] = '{3, 4, 2};
    localparam logic [31:0] DEF      = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] d;
        int          t;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] flush, in_valid, out_ready;
    logic [31:0]   in_data [NI];
    wire  [NI-1:0] in_ready, out_valid;
    wire  [31:0]   out_data [NI];
    wire  [3:0]    occ [NI];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a beat accepted at sample t sits at stage min(age-1, behind the
    // beat ahead), so the oldest beat is visible exactly when its age >= DEPTH.
    // Occupancy equals beats in flight; the input is ready unless every stage
    // is full and the output is stalled, or a flush is active.
    for (genvar gi = 0; gi < NI; gi++) begin : g
        localparam int D   = DEP[gi];
        localparam int CWL = $clog2(D + 1);
        wire [CWL-1:0] occ_w;

        gen_hs_pipe #(.DW(32), .DEPTH(D), .DEFAULT(DEF)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .flush_i     (flush[gi]),
            .in_valid_i  (in_valid[gi]),
            .in_ready_o  (in_ready[gi]),
            .in_data_i   (in_data[gi]),
            .out_valid_o (out_valid[gi]),
            .out_ready_i (out_ready[gi]),
            .out_data_o  (out_data[gi]),
            .occ_o       (occ_w)
        );
        assign occ[gi] = 4'(occ_w);

        beat_t q[$];
        int    s = 0;
        bit    exp_v, exp_r;

        always @(negedge clk) begin
            s++;
            if (!rst_n) begin
                q.delete();
                check(out_valid[gi] == 1'b0, $sformatf("i%0d rst out_valid", gi), 32'(out_valid[gi]), 0);
                check(occ[gi] == 4'd0, $sformatf("i%0d rst occ", gi), 32'(occ[gi]), 0);
                check(out_data[gi] == DEF, $sformatf("i%0d rst out_data", gi), out_data[gi], DEF);
                check(in_ready[gi] == ~flush[gi], $sformatf("i%0d rst in_ready", gi),
                      32'(in_ready[gi]), 32'(~flush[gi]));
            end else begin
                exp_v = (q.size() > 0) && (s - q[0].t >= D);
                exp_r = ((q.size() < D) || out_ready[gi]) && !flush[gi];
                check(out_valid[gi] == exp_v, $sformatf("i%0d out_valid", gi), 32'(out_valid[gi]), 32'(exp_v));
                if (exp_v)
                    check(out_data[gi] == q[0].d, $sformatf("i%0d out_data", gi), out_data[gi], q[0].d);
                check(32'(occ[gi]) == 32'(q.size()), $sformatf("i%0d occ", gi), 32'(occ[gi]), 32'(q.size()));
                check(in_ready[gi] == exp_r, $sformatf("i%0d in_ready", gi), 32'(in_ready[gi]), 32'(exp_r));
                if (exp_v && out_ready[gi]) void'(q.pop_front());
                if (flush[gi]) q.delete();
                else if (in_valid[gi] && exp_r) q.push_back('{in_data[gi], s});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            flush[i]     = 1'b0;
            out_ready[i] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc [NI];
        int waited;

        for (int i = 0; i < NI; i++) begin
            in_data[i] = '0;
        end
        in_valid = '0; flush = '0; out_ready = '0;

        // Reset and idle.
        repeat (3) tick();
        check(in_ready[0] == 1'b1, "rst in_ready d3", 32'(in_ready[0]), 1);
        check(out_data[0] == DEF, "rst out_data d3", out_data[0], DEF);
        rst_n = 1'b1;
        idle_all();
        repeat (3) tick();

        // Streaming, DEPTH=3.
        for (int v = 1; v <= 16; v++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'(v);
            tick();
        end
        in_valid[0] = 1'b0;
        repeat (6) tick();

        // Full stall, DEPTH=3.
        out_ready[0] = 1'b0;
        for (int v = 0; v < 4; v++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'hA + 32'(v);
            if (v < 3) tick();
        end
        @(negedge clk);
        check(occ[0] == 4'd3, "stall occ", 32'(occ[0]), 3);
        check(in_ready[0] == 1'b0, "stall in_ready", 32'(in_ready[0]), 0);
        tick();
        out_ready[0] = 1'b1;
        @(negedge clk);
        check(in_ready[0] == 1'b1, "release in_ready", 32'(in_ready[0]), 1);
        check(out_data[0] == 32'hA, "release head", out_data[0], 32'hA);
        tick();
        in_valid[0] = 1'b0;
        repeat (6) tick();

        // Bubble collapse, DEPTH=4.
        out_ready[1] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            in_valid[1] = (p % 2 == 0);
            in_data[1]  = (p == 0) ? 32'h11 : 32'h22;
            tick();
        end
        in_valid[1] = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check(occ[1] == 4'd2, "bubble occ", 32'(occ[1]), 2);
        check(in_ready[1] == 1'b1, "bubble in_ready", 32'(in_ready[1]), 1);
        check(out_data[1] == 32'h11, "bubble head", out_data[1], 32'h11);
        tick();
        out_ready[1] = 1'b1;
        @(negedge clk);
        check(out_valid[1] == 1'b1, "bubble first out", 32'(out_valid[1]), 1);
        tick();
        @(negedge clk);
        check(out_valid[1] == 1'b1 && out_data[1] == 32'h22, "bubble packed second",
              out_data[1], 32'h22);
        tick();
        repeat (3) tick();

        // Flush with two beats held and a beat offered.
        out_ready[0] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'h31 + 32'(v);
            tick();
        end
        in_valid[0] = 1'b0;
        repeat (3) tick();
        flush[0] = 1'b1; out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 32'h99;
        @(negedge clk);
        check(in_ready[0] == 1'b0, "flush in_ready", 32'(in_ready[0]), 0);
        check(out_valid[0] == 1'b1 && out_data[0] == 32'h31, "flush head", out_data[0], 32'h31);
        tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        @(negedge clk);
        check(occ[0] == 4'd0, "post flush occ", 32'(occ[0]), 0);
        check(out_valid[0] == 1'b0, "post flush out_valid", 32'(out_valid[0]), 0);
        tick();

        // Random traffic on all instances.
        for (int i = 0; i < NI; i++) acc[i] = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (acc[i] || !in_valid[i]) begin
                    in_valid[i] = ($urandom_range(0, 3) != 0);
                    in_data[i]  = $urandom;
                end
                out_ready[i] = ($urandom_range(0, 2) != 0);
                flush[i]     = ($urandom_range(0, 39) == 0);
            end
            @(negedge clk);
            for (int i = 0; i < NI; i++) acc[i] = in_valid[i] && in_ready[i];
            tick();
        end
        idle_all();
        repeat (10) tick();

        // Asynchronous reset mid-cycle, DEPTH=2.
        out_ready[2] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            in_valid[2] = 1'b1;
            in_data[2]  = 32'h71 + 32'(v);
            tick();
        end
        in_valid[2] = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check(occ[2] == 4'd2, "pre reset occ", 32'(occ[2]), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(out_valid[2] == 1'b0, "async out_valid", 32'(out_valid[2]), 0);
        check(occ[2] == 4'd0, "async occ", 32'(occ[2]), 0);
        check(out_data[2] == DEF, "async out_data", out_data[2], DEF);
        check(in_ready[2] == 1'b1, "async in_ready", 32'(in_ready[2]), 1);
        tick();
        rst_n = 1'b1;
        out_ready[2] = 1'b1;
        tick();
        in_valid[2] = 1'b1;
        in_data[2]  = 32'h55;
        @(negedge clk);
        tick();
        in_valid[2] = 1'b0;
        waited = 1;
        @(negedge clk);
        while (!out_valid[2] && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check(waited == 2, "0x55 latency", 32'(waited), 2);
        check(out_data[2] == 32'h55, "0x55 data", out_data[2], 32'h55);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
